// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: EX-stage redirect sequencer for taken branches/jumps.
// Latches the target, drives PC-select/flush/stall until fetch acks, and keeps stats.
module branch_redirect_ctrl #(
    parameter logic [5:0] J_OPCODE   = 6'd2,
    parameter logic [5:0] BEQ_OPCODE = 6'd4,
    parameter logic [5:0] BNE_OPCODE = 6'd5,
    parameter int         CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 IDEX_Valid,
    input  logic [5:0]           IDEX_OpCode,
    input  logic                 Zero,
    input  logic [31:0]          BranchAddress,
    input  logic                 FetchAck,
    input  logic                 ClearStats,
    output logic                 PCSrc,
    output logic [31:0]          PCTarget,
    output logic                 Flush_IFID,
    output logic                 Flush_IDEX,
    output logic                 Stall,
    output logic [CNT_WIDTH-1:0] BranchCount,
    output logic [CNT_WIDTH-1:0] TakenCount
);
    typedef enum logic [1:0] {IDLE, REDIRECT, WAIT_ACK} state_t;

    state_t                state_q, state_d;
    logic [31:0]           target_q, target_d;
    logic [CNT_WIDTH-1:0]  br_cnt_q, br_cnt_d, tk_cnt_q, tk_cnt_d;
    logic                  is_br, taken;

    // Only IDLE sees a real instruction; other states hold a wrong-path one.
    always_comb begin
        is_br = IDEX_Valid && state_q == IDLE &&
                (IDEX_OpCode == J_OPCODE || IDEX_OpCode == BEQ_OPCODE || IDEX_OpCode == BNE_OPCODE);
        taken = IDEX_Valid && state_q == IDLE &&
                (IDEX_OpCode == J_OPCODE || (IDEX_OpCode == BEQ_OPCODE && Zero) ||
                 (IDEX_OpCode == BNE_OPCODE && !Zero));
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                if (taken) begin
                    state_d  = REDIRECT;
                    target_d = BranchAddress;
                end
            end
            REDIRECT: state_d = FetchAck ? IDLE : WAIT_ACK;
            WAIT_ACK: state_d = FetchAck ? IDLE : WAIT_ACK;
            default:  state_d = IDLE;
        endcase
        br_cnt_d = ClearStats ? '0 : br_cnt_q + CNT_WIDTH'(is_br);
        tk_cnt_d = ClearStats ? '0 : tk_cnt_q + CNT_WIDTH'(taken);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            br_cnt_q <= br_cnt_d;
            tk_cnt_q <= tk_cnt_d;
        end
    end

    always_comb begin
        PCSrc      = state_q != IDLE;
        Flush_IFID = state_q != IDLE;
        Flush_IDEX = state_q == REDIRECT;
        Stall      = state_q == WAIT_ACK;
    end

    assign PCTarget    = target_q;
    assign BranchCount = br_cnt_q;
    assign TakenCount  = tk_cnt_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed + random stimulus against a redirect-in-progress model.
module tb_branch_redirect_ctrl;
    localparam int CW = 4;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          IDEX_Valid = 0;
    logic [5:0]    IDEX_OpCode = 0;
    logic          Zero = 0;
    logic [31:0]   BranchAddress = 0;
    logic          FetchAck = 0;
    logic          ClearStats = 0;
    logic          PCSrc, Flush_IFID, Flush_IDEX, Stall;
    logic [31:0]   PCTarget;
    logic [CW-1:0] BranchCount, TakenCount;

    int checks = 0;
    int failures = 0;

    // Reference: a redirect is either not in progress, in its first cycle, or waiting.
    bit          m_active = 0, m_first = 0;
    logic [31:0] m_tgt = 0;
    int          m_bc = 0, m_tc = 0;

    branch_redirect_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .IDEX_Valid(IDEX_Valid), .IDEX_OpCode(IDEX_OpCode),
        .Zero(Zero), .BranchAddress(BranchAddress), .FetchAck(FetchAck),
        .ClearStats(ClearStats), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .Flush_IFID(Flush_IFID), .Flush_IDEX(Flush_IDEX), .Stall(Stall),
        .BranchCount(BranchCount), .TakenCount(TakenCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("PCSrc", 32'(PCSrc), 32'(m_active));
        chk("Flush_IFID", 32'(Flush_IFID), 32'(m_active));
        chk("Flush_IDEX", 32'(Flush_IDEX), 32'(m_active && m_first));
        chk("Stall", 32'(Stall), 32'(m_active && !m_first));
        chk("PCTarget", PCTarget, m_tgt);
        chk("BranchCount", 32'(BranchCount), 32'(m_bc % (1 << CW)));
        chk("TakenCount", 32'(TakenCount), 32'(m_tc % (1 << CW)));
    endtask

    task automatic model_reset();
        m_active = 0; m_first = 0; m_tgt = 0; m_bc = 0; m_tc = 0;
    endtask

    task automatic cycle(input logic v, input logic [5:0] op, input logic z,
                         input logic [31:0] a, input logic ack, input logic clr);
        bit br, tk;
        IDEX_Valid = v; IDEX_OpCode = op; Zero = z; BranchAddress = a;
        FetchAck = ack; ClearStats = clr;
        br = v && (op == 6'd2 || op == 6'd4 || op == 6'd5);
        tk = v && (op == 6'd2 || (op == 6'd4 && z) || (op == 6'd5 && !z));
        @(posedge clk);
        #1;
        if (!m_active) begin
            if (br) m_bc++;
            if (tk) begin
                m_tc++; m_tgt = a; m_active = 1; m_first = 1;
            end
        end else if (ack) m_active = 0;
        else m_first = 0;
        if (clr) begin
            m_bc = 0; m_tc = 0;
        end
        check_all();
    endtask

    initial begin
        #2;
        check_all();
        #10 rst_n = 1;
        // BEQ taken, fast ack
        cycle(1, 6'd4, 1, 32'h40, 0, 0);
        chk("beq_pcsrc", 32'(PCSrc), 32'd1);
        chk("beq_target", PCTarget, 32'h40);
        cycle(0, 6'd0, 0, 0, 1, 0);
        chk("beq_idle", 32'(PCSrc), 32'd0);
        chk("beq_counts", {TakenCount, BranchCount}, {4'd1, 4'd1});
        // BNE not taken, then J
        cycle(1, 6'd5, 1, 32'h500, 0, 0);
        chk("bne_nored", 32'(PCSrc), 32'd0);
        cycle(1, 6'd2, 0, 32'h1000, 0, 0);
        chk("j_target", PCTarget, 32'h1000);
        cycle(0, 6'd0, 0, 0, 1, 0);
        chk("j_counts", {TakenCount, BranchCount}, {4'd2, 4'd3});
        // Delayed ack
        cycle(1, 6'd4, 1, 32'h80, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 6'd0, 0, 0, 0, 0);
            chk("wait_stall", 32'(Stall), 32'd1);
        end
        cycle(0, 6'd0, 0, 0, 1, 0);
        chk("ack_idle", 32'(PCSrc), 32'd0);
        // Wrong-path J during redirect is ignored
        cycle(1, 6'd4, 1, 32'hC0, 0, 0);
        cycle(1, 6'd2, 0, 32'h2000, 0, 0);
        chk("wrongpath_tgt", PCTarget, 32'hC0);
        cycle(1, 6'd2, 0, 32'h2000, 1, 0);
        // Reset mid WAIT_ACK, between edges
        cycle(1, 6'd2, 0, 32'h3000, 0, 0);
        cycle(0, 6'd0, 0, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all();
        chk("rst_stall", 32'(Stall), 32'd0);
        #1 rst_n = 1;
        // Stats wrap and clear priority
        for (int i = 0; i < 17; i++) begin
            cycle(1, 6'd2, 0, 32'(i * 4), 0, 0);
            cycle(0, 6'd0, 0, 0, 1, 0);
        end
        chk("wrap_taken", 32'(TakenCount), 32'd1);
        cycle(1, 6'd2, 0, 32'h44, 0, 1);
        chk("clear_counts", {TakenCount, BranchCount}, 8'd0);
        cycle(0, 6'd0, 0, 0, 1, 0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            case ($urandom_range(0, 3))
                0: op = 6'd2;
                1: op = 6'd4;
                2: op = 6'd5;
                default: op = 6'($urandom);
            endcase
            cycle(1'($urandom), op, 1'($urandom), $urandom, 1'($urandom),
                  $urandom_range(0, 19) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

This block sequences branch and jump redirection in the pipelined CPU. It sits in the EX stage beside the branch-target adder and decides whether the instruction in ID/EX redirects the PC. When it does, it latches the computed target and drives the PC-select and flush signals for the front end. It holds the redirect until instruction fetch acknowledges it, and keeps branch and redirect statistics.

## Interface
- `J_OPCODE`, default 6'd2: jump opcode, always taken.
- `BEQ_OPCODE`, default 6'd4: branch-on-equal opcode, taken when `Zero`=1.
- `BNE_OPCODE`, default 6'd5: branch-on-not-equal opcode, taken when `Zero`=0.
- `CNT_WIDTH`, default 16: width of the statistics counters.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `IDEX_Valid` input 1: the ID/EX register holds a real, non-bubble instruction.
- `IDEX_OpCode` input 6: opcode of the ID/EX instruction.
- `Zero` input 1: ALU zero flag for the ID/EX instruction.
- `BranchAddress` input 32: target from the branch-target adder, valid in the same cycle.
- `FetchAck` input 1: instruction fetch has loaded `PCTarget` into the PC this cycle.
- `ClearStats` input 1: synchronous clear of both counters.
- `PCSrc` output 1: PC mux selects `PCTarget`.
- `PCTarget` output 32: latched redirect target.
- `Flush_IFID` output 1: bubble the IF/ID register at the next edge.
- `Flush_IDEX` output 1: bubble the ID/EX register at the next edge.
- `Stall` output 1: freeze PC and IF/ID; the back end keeps draining.
- `BranchCount` output CNT_WIDTH: resolved branch and jump instructions.
- `TakenCount` output CNT_WIDTH: redirects issued.

## Operation
- `is_br` = `IDEX_Valid` & (op==J | op==BEQ | op==BNE).
- `taken` = `IDEX_Valid` & ((op==J) | (op==BEQ & `Zero`) | (op==BNE & ~`Zero`)).
- Both `is_br` and `taken` are qualified by state==IDLE. In REDIRECT and WAIT_ACK, ID/EX holds a wrong-path instruction, and that instruction must be ignored and not counted.
- The FSM has three states: IDLE, REDIRECT and WAIT_ACK.
- IDLE:
  - All control outputs are 0.
  - On `taken`, latch `PCTarget` <= `BranchAddress` and go to REDIRECT.
  - Otherwise stay in IDLE.
- REDIRECT (exactly 1 cycle):
  - `PCSrc`=1, `Flush_IFID`=1, `Flush_IDEX`=1, `Stall`=0.
  - If `FetchAck`=1, go to IDLE; otherwise go to WAIT_ACK.
- WAIT_ACK:
  - `PCSrc`=1, `Flush_IFID`=1, `Stall`=1, `Flush_IDEX`=0.
  - Stay until `FetchAck`=1, then go to IDLE.
- Control outputs are Moore outputs decoded from the state register only. No input reaches an output combinationally.
- `PCTarget` changes only on the IDLE->REDIRECT capture. It holds its value after the block returns to IDLE.
- `BranchCount` increments on an IDLE cycle with `is_br`=1.
- `TakenCount` increments on an IDLE cycle with `taken`=1.
- Counters wrap modulo 2^CNT_WIDTH.
- `ClearStats` takes priority over an increment in the same cycle; the result is 0.
- Opcodes not in {J, BEQ, BNE} never redirect, regardless of `Zero`.

## Timing
- Latency: branch resolved in cycle N (IDLE, `taken`=1) -> `PCSrc`/flush outputs high in cycle N+1.
- The minimum redirect lasts 1 cycle, when `FetchAck`=1 in REDIRECT. A redirect spans 1+k cycles when the ack arrives k cycles after REDIRECT.
- `FetchAck` is ignored in IDLE.
- Back-to-back taken branches: the earliest next capture is in the first IDLE cycle after the ack. The cycle N+2 window cannot resolve a branch because ID/EX was flushed.
- Reset: asserting `rst_n`=0 at any time, including mid-WAIT_ACK, immediately forces the following, with no clock needed:
  - state = IDLE;
  - `PCSrc`, `Flush_IFID`, `Flush_IDEX`, `Stall` = 0;
  - `PCTarget` = 0;
  - `BranchCount`, `TakenCount` = 0.
- After `rst_n` rises, the first edge evaluates IDLE normally.

## Test plan
- BEQ taken with fast ack:
  - Stimulus: op=4, `Zero`=1, `BranchAddress`=0x00000040, `FetchAck`=1 in cycle N+1.
  - Required response: N+1 has `PCSrc`=`Flush_IFID`=`Flush_IDEX`=1 and `PCTarget`=0x40; N+2 is back in IDLE; `BranchCount`=1, `TakenCount`=1.
- BNE not taken and J:
  - Stimulus: op=5 with `Zero`=1, then op=2 with `BranchAddress`=0x00001000.
  - Required response: no redirect for the BNE; the J redirects to 0x1000; `BranchCount`=2, `TakenCount`=1.
- Delayed ack:
  - Stimulus: taken branch; `FetchAck` held 0 for 3 cycles after REDIRECT, then asserted.
  - Required response: 1 REDIRECT cycle, then 3 WAIT_ACK cycles followed by the ack cycle with `Stall`=1 and `PCSrc`=1, then IDLE.
- Wrong-path suppression:
  - Stimulus: taken BEQ, then the next cycle presents a valid J with target 0x2000.
  - Required response: `PCTarget` stays at the first target; `BranchCount`=1.
- Reset mid-redirect:
  - Stimulus: drop `rst_n` during WAIT_ACK between clock edges.
  - Required response: `PCSrc`/`Stall`/flush outputs go to 0 before the next edge; `PCTarget`=0 and both counters=0.
- Stats:
  - Stimulus: run CNT_WIDTH=4 with 17 taken jumps, then assert `ClearStats` in the same cycle as an 18th resolution.
  - Required response: `TakenCount`=1 after the wrap; after the clear cycle, both counters=0.
